// File: rtl/cache_pmem_adapter.sv
// cache_pmem_adapter: turns single-cycle cache line requests into LINE_W/BEAT_W-beat bursts on
// the physical memory bus and returns the assembled line with a one-cycle pmem_resp.
// Optional feature macro: PMEM_ADAPTER_TIMEOUT_EN adds a stall counter that aborts a burst
// after TIMEOUT stalled cycles and flags it through pmem_error.
module cache_pmem_adapter #(
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned BEAT_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // Cache side
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              pmem_error,
  // Memory bus side
  output logic              bus_cmd_valid,
  input  logic              bus_cmd_ready,
  output logic              bus_cmd_we,
  output logic [ADDR_W-1:0] bus_cmd_addr,
  output logic [BEAT_W-1:0] bus_wdata,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  input  logic [BEAT_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int unsigned Beats    = LINE_W / BEAT_W;
  localparam int unsigned BeatIdxW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffW     = $clog2(LINE_W / 8);
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [ADDR_W-OffW-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic [LINE_W-1:0]      rdata_q, rdata_d;
  logic [BeatIdxW-1:0]    beat_q, beat_d;

  logic cmd_hs, wbeat_hs, rbeat_hs;
  logic timeout;
  logic err_flag;

  assign cmd_hs   = (state_q == StCmd) && bus_cmd_ready;
  assign wbeat_hs = (state_q == StWdata) && bus_wready;
  // bus_rvalid only matters while a read burst is in flight
  assign rbeat_hs = (state_q == StRdata) && bus_rvalid;

`ifdef PMEM_ADAPTER_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;
  logic       err_q, err_d;
  logic       busy, any_hs;

  assign busy    = (state_q == StCmd) || (state_q == StWdata) || (state_q == StRdata);
  assign any_hs  = cmd_hs || wbeat_hs || rbeat_hs;
  // Fires on the stalled cycle that brings the count up to TIMEOUT
  assign timeout = busy && !any_hs && ((stall_q + 8'd1) == 8'(TIMEOUT));

  // Stall counter and sticky error flag for the current burst
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if ((state_q == StIdle) && (pmem_read || pmem_write)) begin
      stall_d = '0;
      err_d   = 1'b0;
    end else if (busy) begin
      stall_d = any_hs ? 8'd0 : (stall_q + 8'd1);
      if (timeout) err_d = 1'b1;
    end
  end

  // Stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_flag = err_q;

  logic unused_addr;
  assign unused_addr = ^pmem_address[OffW-1:0];
`else
  assign timeout  = 1'b0;
  assign err_flag = 1'b0;

  logic unused_cfg;
  assign unused_cfg = (^pmem_address[OffW-1:0]) ^ (TIMEOUT == 0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic; a write wins over a simultaneous read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pmem_write || pmem_read) state_d = StCmd;
      StCmd: begin
        if (timeout)            state_d = StResp;
        else if (bus_cmd_ready) state_d = we_q ? StWdata : StRdata;
      end
      StWdata: begin
        if (timeout)                                 state_d = StResp;
        else if (bus_wready && (beat_q == LastBeat)) state_d = StResp;
      end
      StRdata: begin
        if (timeout)                                 state_d = StResp;
        else if (bus_rvalid && (beat_q == LastBeat)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    pmem_resp     = (state_q == StResp);
    pmem_error    = pmem_resp && err_flag;
    bus_cmd_valid = (state_q == StCmd);
    bus_wvalid    = (state_q == StWdata);
  end

  // Request latching, beat counter and read-line assembly
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    if (state_q == StIdle) begin
      if (pmem_write) begin
        we_d    = 1'b1;
        addr_d  = pmem_address[ADDR_W-1:OffW];
        wdata_d = pmem_wdata;
      end else if (pmem_read) begin
        we_d   = 1'b0;
        addr_d = pmem_address[ADDR_W-1:OffW];
      end
    end
    if (cmd_hs) beat_d = '0;
    if (wbeat_hs) beat_d = beat_q + BeatIdxW'(1);
    if (rbeat_hs) begin
      rdata_d[beat_q*BEAT_W +: BEAT_W] = bus_rdata;
      beat_d = beat_q + BeatIdxW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
    end
  end

  assign bus_cmd_we   = we_q;
  assign bus_cmd_addr = {addr_q, {OffW{1'b0}}};
  assign bus_wdata    = wdata_q[beat_q*BEAT_W +: BEAT_W];
  assign pmem_rdata   = rdata_q;

endmodule

// File: tb/tb_cache_pmem_adapter.sv
// Bench for cache_pmem_adapter: a per-transaction cycle schedule (phase waits -> expected
// valid/resp timing) plus a line-level memory model, checked every cycle by one compare process.
module tb_cache_pmem_adapter;
  localparam int LW  = 128;
  localparam int BW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp, pmem_error;
  logic          bus_cmd_valid, bus_cmd_ready, bus_cmd_we;
  logic [AW-1:0] bus_cmd_addr;
  logic [BW-1:0] bus_wdata, bus_rdata;
  logic          bus_wvalid, bus_wready, bus_rvalid;

  cache_pmem_adapter #(.LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_error(pmem_error),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready), .bus_cmd_we(bus_cmd_we),
    .bus_cmd_addr(bus_cmd_addr), .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid),
    .bus_wready(bus_wready), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_pass = 0;
  int n_total = 0;

  // Model state
  bit            active = 1'b0;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_line;
  logic [LW-1:0] exp_rdata = '0;
  int            req_edge = 0;
  int            resp_ofs = 0;
  bit            sch_to = 1'b0;
  int            exp_resp_cnt = 0;
  bit            ph_v[64];
  bit            ph_hs[64];
  int            ph_idx[64];

  // Observations for the literal checks
  bit            obs_cmd_seen;
  logic [AW-1:0] obs_cmd_addr;
  logic          obs_cmd_we;
  int            obs_cmd_edge;
  int            obs_resp_ofs;
  int            obs_resp_edge;
  int            obs_txn_resp;
  logic          obs_err;
  int            obs_resp_cnt = 0;
  logic [BW-1:0] obs_wb[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Per-cycle comparison against the model
  always begin : compare
    int  ofs;
    bit  inwin, e_cmdv, e_wv, e_resp;
    @(negedge clk);
    #1;
    ofs    = edge_cnt - req_edge;
    inwin  = active && (ofs >= 0) && (ofs < 64);
    e_cmdv = inwin && ph_v[ofs] && (ph_idx[ofs] == 0);
    e_wv   = inwin && cur_we && ph_v[ofs] && (ph_idx[ofs] > 0);
    e_resp = active && (ofs == resp_ofs);
    chk("cmd_valid", LW'(bus_cmd_valid), LW'(e_cmdv));
    chk("wvalid", LW'(bus_wvalid), LW'(e_wv));
    chk("resp", LW'(pmem_resp), LW'(e_resp));
    chk("error", LW'(pmem_error), LW'(e_resp && sch_to));
    if (e_cmdv) begin
      chk("cmd_addr", LW'(bus_cmd_addr), LW'(cur_addr));
      chk("cmd_we", LW'(bus_cmd_we), LW'(cur_we));
    end
    if (e_wv) chk("wdata", LW'(bus_wdata), LW'(cur_line[(ph_idx[ofs]-1)*BW +: BW]));
    if (!(active && !cur_we) || e_resp) chk("rdata", pmem_rdata, exp_rdata);
    if (bus_cmd_valid && !obs_cmd_seen) begin
      obs_cmd_seen = 1'b1;
      obs_cmd_addr = bus_cmd_addr;
      obs_cmd_we   = bus_cmd_we;
      obs_cmd_edge = edge_cnt;
    end
    if (bus_wvalid && bus_wready) obs_wb.push_back(bus_wdata);
    if (pmem_resp) begin
      obs_resp_cnt++;
      obs_txn_resp++;
      obs_resp_ofs  = ofs;
      obs_resp_edge = edge_cnt;
      obs_err       = pmem_error;
    end
  end

  task automatic clear_bus();
    bus_cmd_ready = 1'b0;
    bus_wready    = 1'b0;
    bus_rvalid    = 1'b0;
    bus_rdata     = '0;
  endtask

  // One line transaction; waits are stall cycles before each handshake (cmd, beats 0..3).
  // Entered and left on a negedge. abort_ofs > 0 pulls rst_n in that cycle.
  task automatic run_txn(input logic wr, input logic rd, input logic [AW-1:0] addr,
                         input logic [LW-1:0] lw, input logic [LW-1:0] lr,
                         input int cw, input int w0, input int w1, input int w2, input int w3,
                         input int abort_ofs);
    int w[5];
    int t, st;
    bit to;
    w = '{cw, w0, w1, w2, w3};
    foreach (ph_v[i]) begin
      ph_v[i] = 1'b0; ph_hs[i] = 1'b0; ph_idx[i] = 0;
    end
    t  = 1;
    to = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (!to) begin
        st = w[p];
`ifdef PMEM_ADAPTER_TIMEOUT_EN
        if (st >= TMO) begin st = TMO; to = 1'b1; end
`endif
        for (int j = 0; j < st; j++) begin ph_v[t] = 1'b1; ph_idx[t] = p; t++; end
        if (!to) begin ph_v[t] = 1'b1; ph_hs[t] = 1'b1; ph_idx[t] = p; t++; end
      end
    end
    resp_ofs = t;
    sch_to   = to;
    cur_we   = wr;
    cur_addr = addr & 16'hFFF0;
    cur_line = lw;
    if (!wr && rd && !to) exp_rdata = lr;
    req_edge     = edge_cnt;
    active       = 1'b1;
    obs_cmd_seen = 1'b0;
    obs_txn_resp = 0;
    obs_wb.delete();
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = addr;
    pmem_wdata   = lw;
    for (int o = 1; o <= resp_ofs + 1; o++) begin
      @(negedge clk);
      if (o == abort_ofs) begin
        rst_n      = 1'b0;
        active     = 1'b0;
        exp_rdata  = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        clear_bus();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      // Request fields move mid-burst; the adapter must not notice
      if (o == 2) begin pmem_address = ~addr; pmem_wdata = ~lw; end
      if (o == resp_ofs) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        exp_resp_cnt++;
      end
      if (o == resp_ofs + 1) begin
        active = 1'b0;
        clear_bus();
      end else begin
        bus_cmd_ready = ph_hs[o] && (ph_idx[o] == 0);
        bus_wready    = ph_hs[o] && (ph_idx[o] > 0) && cur_we;
        // During writes, rvalid carries junk that must never reach the read line
        bus_rvalid    = cur_we ? 1'b1 : (ph_hs[o] && (ph_idx[o] > 0));
        if (cur_we) bus_rdata = 32'hDEADBEEF;
        else if (ph_idx[o] > 0) bus_rdata = lr[(ph_idx[o]-1)*BW +: BW];
        else bus_rdata = '0;
      end
    end
  endtask

  localparam logic [LW-1:0] LineA  = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [LW-1:0] LineW  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] LineWb = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [LW-1:0] LineAl = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] LineB  = 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0;
  localparam logic [LW-1:0] LineC  = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

  initial begin : stim
    int gap_edge;
    rst_n = 1'b1;
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
    clear_bus();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_addr", LW'(bus_cmd_addr), '0);
    chk("rst_cmd_we", LW'(bus_cmd_we), '0);
    chk("rst_wdata", LW'(bus_wdata), '0);
    chk("rst_rdata", pmem_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read, zero wait
    run_txn(1'b0, 1'b1, 16'h1234, '0, LineA, 0, 0, 0, 0, 0, -1);
    chk("rd_cmd_addr", LW'(obs_cmd_addr), LW'(16'h1230));
    chk("rd_cmd_we", LW'(obs_cmd_we), '0);
    chk("rd_resp_ofs", LW'(obs_resp_ofs), LW'(6));
    chk("rd_line", pmem_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    // Write with 2 wait cycles on beat 1
    run_txn(1'b1, 1'b0, 16'h2000, LineW, '0, 0, 0, 2, 0, 0, -1);
    chk("wr_resp_ofs", LW'(obs_resp_ofs), LW'(8));
    chk("wr_nbeats", LW'(obs_wb.size()), LW'(4));
    if (obs_wb.size() == 4) begin
      chk("wr_beat0", LW'(obs_wb[0]), LW'(32'h11111111));
      chk("wr_beat1", LW'(obs_wb[1]), LW'(32'h22222222));
      chk("wr_beat2", LW'(obs_wb[2]), LW'(32'h33333333));
      chk("wr_beat3", LW'(obs_wb[3]), LW'(32'h44444444));
    end
    chk("wr_keeps_rdata", pmem_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    // Write-back then allocate, back to back
    run_txn(1'b1, 1'b0, 16'h2000, LineWb, '0, 0, 0, 0, 0, 0, -1);
    chk("wb_we", LW'(obs_cmd_we), LW'(1));
    gap_edge = obs_resp_edge;
    run_txn(1'b0, 1'b1, 16'h3000, '0, LineAl, 0, 0, 0, 0, 0, -1);
    chk("alloc_we", LW'(obs_cmd_we), '0);
    chk("wb_alloc_gap", LW'(obs_cmd_edge - gap_edge), LW'(2));

    // Simultaneous read and write: write wins
    run_txn(1'b1, 1'b1, 16'h4567, LineC, LineB, 1, 0, 0, 0, 0, -1);
    chk("both_we", LW'(obs_cmd_we), LW'(1));
    chk("both_addr", LW'(obs_cmd_addr), LW'(16'h4560));

    // Read with mixed stalls
    run_txn(1'b0, 1'b1, 16'h5ABC, '0, LineB, 2, 1, 0, 3, 0, -1);
    chk("rdw_resp_ofs", LW'(obs_resp_ofs), LW'(12));

    // Reset in RDATA after beat 1
    run_txn(1'b0, 1'b1, 16'h6000, '0, LineC, 0, 0, 0, 0, 0, 4);
    chk("abort_no_resp", LW'(obs_txn_resp), '0);
    chk("abort_rdata", pmem_rdata, '0);
    run_txn(1'b0, 1'b1, 16'h7000, '0, LineA, 0, 0, 0, 0, 0, -1);
    chk("fresh_rd_line", pmem_rdata, LineA);

    // Command never accepted
    run_txn(1'b0, 1'b1, 16'h8000, '0, LineB, 30, 0, 0, 0, 0, 20);
`ifdef PMEM_ADAPTER_TIMEOUT_EN
    chk("to_resp_ofs", LW'(obs_resp_ofs), LW'(5));
    chk("to_error", LW'(obs_err), LW'(1));
    chk("to_keeps_rdata", pmem_rdata, LineA);
`else
    chk("stall_no_resp", LW'(obs_txn_resp), '0);
`endif

    @(negedge clk);
    chk("resp_count", LW'(obs_resp_cnt), LW'(exp_resp_cnt));
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
